mem_bank_router: RTL and testbench

Parametrised memory front-end between the CPU memory stage and N external SRAM bank controllers, plus one memory-mapped UART status word. Replaces fixed two-RAM, combinational routing with a registered request/acknowledge FSM. Adds per-transaction timeout, an error flag and a wrapping transaction counter. The CPU stalls on a held `cpu_rd`/`cpu_wr` level until `cpu_done` pulses.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/mem_bank_router.sv | 153 +++++++++++++++
 tb/tb_mem_bank_router.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory bank router: FSM states,
// UART status word layout and the bank-select width helper.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_HOLD
  } mem_state_t;

  localparam logic [15:0] STATUS_ADDR_DEF = 16'hBF01;
  localparam int          STAT_TX_RDY     = 0;
  localparam int          STAT_RX_RDY     = 1;

  function automatic int calc_sel_w(input int num_banks);
    return $clog2(num_banks);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Clear/enable wait counter; expired_o flags the cycle in which the
// count reaches TIMEOUT, so a request lasts exactly TIMEOUT enabled cycles.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds completed cycles, so this cycle is number count_q+1
  assign expired_o = en_i && (({1'b0, count_q} + 17'd1) == 17'(TIMEOUT));

endmodule

// File: rtl/mem_bank_router.sv
// CPU memory-stage front-end: routes each request to one SRAM bank or the
// UART status word through a registered request/acknowledge FSM.
module mem_bank_router
  import mem_pkg::*;
#(
  parameter int              ADDR_W      = 16,
  parameter int              DATA_W      = 16,
  parameter int              NUM_BANKS   = 2,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_ADDR_DEF),
  parameter int              TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_rd,
  input  logic                        cpu_wr,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_done,
  output logic                        cpu_err,
  output logic [NUM_BANKS-1:0]        bank_req,
  output logic                        bank_we,
  output logic [ADDR_W-1:0]           bank_addr,
  output logic [DATA_W-1:0]           bank_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
  input  logic [NUM_BANKS-1:0]        bank_ack,
  input  logic                        uart_rx_ready,
  input  logic                        uart_tx_ready,
  output logic [15:0]                 txn_count
);

  localparam int SEL_W = calc_sel_w(NUM_BANKS);

  mem_state_t           state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_BANKS-1:0] req_q, req_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [15:0]          txn_q, txn_d;
  logic                 tmr_clr, tmr_en, tmr_expired;
  logic [DATA_W-1:0]    sel_rdata, status_word;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  assign sel_rdata = bank_rdata[int'(sel_q)*DATA_W +: DATA_W];

  always_comb begin
    status_word              = '1;
    status_word[STAT_RX_RDY] = uart_rx_ready;
    status_word[STAT_TX_RDY] = uart_tx_ready;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    txn_d   = txn_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_rd || cpu_wr) begin
          if (cpu_addr == STATUS_ADDR) begin
            rdata_d = cpu_wr ? '0 : status_word;
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            sel_d   = cpu_addr[ADDR_W-1 -: SEL_W];
            req_d   = NUM_BANKS'(1) << cpu_addr[ADDR_W-1 -: SEL_W];
            we_d    = cpu_wr;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            tmr_clr = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tmr_en = 1'b1;
        // an ack landing on the expiry cycle still counts as success
        if (bank_ack[sel_q]) begin
          req_d   = '0;
          rdata_d = we_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmr_expired) begin
          req_d   = '0;
          rdata_d = '1;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        txn_d   = txn_q + 16'd1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!cpu_rd && !cpu_wr) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      req_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;
  assign cpu_done   = (state_q == S_RESP);
  assign bank_req   = req_q;
  assign bank_we    = we_q;
  assign bank_addr  = addr_q;
  assign bank_wdata = wdata_q;
  assign txn_count  = txn_q;

endmodule

// File: tb/tb_mem_bank_router.sv
// Scoreboard bench for mem_bank_router with four banks and a short timeout.
module tb_mem_bank_router;

  localparam int NB = 4;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [15:0]      cpu_addr = '0, cpu_wdata = '0;
  logic [15:0]      cpu_rdata;
  logic             cpu_done, cpu_err;
  logic [NB-1:0]    bank_req;
  logic             bank_we;
  logic [15:0]      bank_addr, bank_wdata;
  logic [NB*16-1:0] bank_rdata = '0;
  logic [NB-1:0]    bank_ack = '0;
  logic             uart_rx_ready = 1'b0, uart_tx_ready = 1'b0;
  logic [15:0]      txn_count;

  logic [16:0] sb_q[$];
  logic [16:0] sb_e;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_txn = '0;

  mem_bank_router #(
    .ADDR_W(16), .DATA_W(16), .NUM_BANKS(NB), .STATUS_ADDR(16'hBF01), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .bank_req(bank_req), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata), .bank_ack(bank_ack), .uart_rx_ready(uart_rx_ready),
    .uart_tx_ready(uart_tx_ready), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: pop and compare on every completion pulse
  always @(negedge clk) begin
    if (rst && cpu_done) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check_val("rdata", 32'(cpu_rdata), 32'(sb_e[15:0]));
        check_val("err", 32'(cpu_err), 32'(sb_e[16]));
      end
    end
  end

  // ack_after: cycle of bank_req on which to ack (0 = never); other banks get spurious acks
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         input int ack_after, input logic [15:0] ack_data, input logic drop,
                         input logic [15:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_req_cyc);
    int            cyc;
    int            req_cycles;
    logic          done_seen;
    logic [NB-1:0] exp_req;
    exp_req = NB'(1) << addr[15:14];
    for (int b = 0; b < NB; b++) begin
      bank_rdata[b*16 +: 16] = (b == int'(addr[15:14])) ? ack_data : (16'hD000 | 16'(b));
    end
    sb_q.push_back({exp_err, exp_rd});
    cpu_rd = !wr; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
    cyc = 0; req_cycles = 0; done_seen = 1'b0;
    while (!done_seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      bank_ack = '0;
      if (cpu_done) begin
        done_seen = 1'b1;
      end else if (bank_req != '0) begin
        req_cycles++;
        check_val("bank_req_onehot", 32'(bank_req), 32'(exp_req));
        check_val("bank_addr", 32'(bank_addr), 32'(addr));
        check_val("bank_we", 32'(bank_we), 32'(wr));
        check_val("bank_wdata", 32'(bank_wdata), 32'(wd));
        if (drop && req_cycles == 1) begin
          cpu_rd = 1'b0; cpu_wr = 1'b0;
        end
        bank_ack = (req_cycles == ack_after) ? bank_req : ~bank_req;
      end
    end
    check_val("done_seen", 32'(done_seen), 32'd1);
    check_val("latency", 32'(cyc), 32'(exp_lat));
    check_val("req_cycles", 32'(req_cycles), 32'(exp_req_cyc));
    exp_txn = exp_txn + 16'd1;
    repeat (2) begin
      @(negedge clk);
      check_val("hold_quiet", {27'd0, bank_req, cpu_done}, 32'd0);
      check_val("txn_count", 32'(txn_count), 32'(exp_txn));
    end
    $display("txn addr=%h wr=%0d rdata=%h err=%0d lat=%0d txn=%0d",
             addr, wr, cpu_rdata, cpu_err, cyc, txn_count);
    cpu_rd = 1'b0; cpu_wr = 1'b0; bank_ack = '0;
    @(negedge clk);
  endtask

  initial begin
    #2;
    check_val("rst_done", 32'(cpu_done), 32'd0);
    check_val("rst_req", 32'(bank_req), 32'd0);
    check_val("rst_txn", 32'(txn_count), 32'd0);
    check_val("rst_rdata", {15'd0, cpu_err, cpu_rdata}, 32'd0);
    check_val("rst_bank_out", {bank_we, bank_addr, bank_wdata}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    uart_rx_ready = 1; uart_tx_ready = 1;
    run_txn(1'b0, 16'hBF01, 16'h0000, 0, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1, 0);
    uart_rx_ready = 0; uart_tx_ready = 1;
    run_txn(1'b0, 16'hBF01, 16'h0000, 0, 16'h0000, 1'b0, 16'hFFFD, 1'b0, 1, 0);
    uart_rx_ready = 1; uart_tx_ready = 0;
    run_txn(1'b0, 16'hBF01, 16'h0000, 0, 16'h0000, 1'b0, 16'hFFFE, 1'b0, 1, 0);
    run_txn(1'b1, 16'hBF01, 16'h1111, 0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1, 0);
    run_txn(1'b0, 16'h8004, 16'h0000, 3, 16'h1234, 1'b0, 16'h1234, 1'b0, 4, 3);
    run_txn(1'b1, 16'h4010, 16'hABCD, 1, 16'h7777, 1'b0, 16'h0000, 1'b0, 2, 1);
    run_txn(1'b0, 16'h0000, 16'h0000, 0, 16'h2222, 1'b0, 16'hFFFF, 1'b1, TO + 1, TO);
    run_txn(1'b0, 16'h0000, 16'h0000, TO, 16'h3333, 1'b0, 16'h3333, 1'b0, TO + 1, TO);
    run_txn(1'b1, 16'hF000, 16'h5555, 0, 16'h4444, 1'b0, 16'hFFFF, 1'b1, TO + 1, TO);
    run_txn(1'b0, 16'h8100, 16'h0000, 2, 16'h0F0F, 1'b1, 16'h0F0F, 1'b0, 3, 2);
    run_txn(1'b0, 16'hC0FE, 16'h0000, 2, 16'h5A5A, 1'b0, 16'h5A5A, 1'b0, 3, 2);

    // reset in the middle of a bank request
    cpu_rd = 1'b1; cpu_addr = 16'h4000;
    repeat (2) @(negedge clk);
    check_val("pre_rst_req", 32'(bank_req), 32'h2);
    #2 rst = 1'b0;
    #1;
    check_val("async_rst_req", 32'(bank_req), 32'd0);
    check_val("async_rst_txn", 32'(txn_count), 32'd0);
    check_val("async_rst_rdata", {15'd0, cpu_err, cpu_rdata}, 32'd0);
    cpu_rd = 1'b0;
    @(negedge clk); rst = 1'b1; exp_txn = '0;
    @(negedge clk);
    uart_rx_ready = 0; uart_tx_ready = 0;
    run_txn(1'b0, 16'hBF01, 16'h0000, 0, 16'h0000, 1'b0, 16'hFFFC, 1'b0, 1, 0);

    // counter wrap
    force dut.txn_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.txn_q;
    @(negedge clk);
    check_val("txn_preload", 32'(txn_count), 32'hFFFF);
    exp_txn = 16'hFFFF;
    run_txn(1'b0, 16'h4002, 16'h0000, 1, 16'h9999, 1'b0, 16'h9999, 1'b0, 2, 1);
    check_val("txn_wrapped", 32'(txn_count), 32'd0);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
